// File: rtl/dmem_ctrl_pkg.sv
// Shared defaults, FSM state encoding and a sizing helper for the data-memory controller.
package dmem_ctrl_pkg;

    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_DEPTH  = 256;
    localparam int DMEM_RD_LAT = 1;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } dmem_state_e;

    // Index width for a DEPTH-word array; a single-word array still needs one bit.
    function automatic int dmem_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// DEPTH x DATA_W storage: byte-enable synchronous write, 1-cycle registered read, no reset.
module dmem_bank
    import dmem_ctrl_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int DEPTH  = DMEM_DEPTH
) (
    input  logic                      clk,
    input  logic                      we_i,
    input  logic                      re_i,
    input  logic [dmem_aw(DEPTH)-1:0] addr_i,
    input  logic [DATA_W-1:0]         wdata_i,
    input  logic [DATA_W/8-1:0]       be_i,
    output logic [DATA_W-1:0]         rdata_o
);
    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < NB; b++) begin
                if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Valid/ready data-memory controller: post-reset zero-fill, range check, byte-enable
// writes and a 1- or 2-cycle read pipeline in front of dmem_bank.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W         = DMEM_ADDR_W,
    parameter int DATA_W         = DMEM_DATA_W,
    parameter int DEPTH          = DMEM_DEPTH,
    parameter int RD_LAT         = DMEM_RD_LAT,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                wr_err,
    output logic                busy
);
    localparam int NB = DATA_W / 8;
    localparam int AW = dmem_aw(DEPTH);

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
        $error("dmem_ctrl: RD_LAT must be 1 or 2");
    end
    if (DATA_W == 0 || (DATA_W % 8) != 0) begin : g_bad_data_w
        $error("dmem_ctrl: DATA_W must be a non-zero multiple of 8");
    end
    if (ADDR_W < 31 && DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("dmem_ctrl: DEPTH exceeds the ADDR_W address space");
    end

    dmem_state_e       state_q, state_d;
    logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
    logic              acc, in_range;
    logic              bank_we, bank_re;
    logic [AW-1:0]     bank_addr;
    logic [DATA_W-1:0] bank_wdata, bank_rdata;
    logic [NB-1:0]     bank_be;
    logic              rd_vld_q, rd_err_q, wr_err_q;
    logic [DATA_W-1:0] s1_data;
    logic              out_vld, out_err;
    logic [DATA_W-1:0] out_data;

    // Widen by one bit so DEPTH == 2**ADDR_W still compares correctly.
    assign in_range = {1'b0, req_addr} < (ADDR_W+1)'(DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        acc        = 1'b0;
        bank_we    = 1'b0;
        bank_re    = 1'b0;
        bank_addr  = req_addr[AW-1:0];
        bank_wdata = req_wdata;
        bank_be    = req_be;
        unique case (state_q)
            S_CLEAR: begin
                bank_we    = 1'b1;
                bank_addr  = clr_ptr_q;
                bank_wdata = '0;
                bank_be    = '1;
                if (clr_ptr_q == AW'(DEPTH - 1)) state_d = S_IDLE;
                else                             clr_ptr_d = clr_ptr_q + 1'b1;
            end
            S_IDLE: begin
                acc     = req_valid && !rst;
                bank_we = acc && req_we && in_range;
                bank_re = acc && !req_we && in_range;
            end
            default: state_d = S_IDLE;
        endcase
    end

    dmem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_bank (
        .clk     (clk),
        .we_i    (bank_we),
        .re_i    (bank_re),
        .addr_i  (bank_addr),
        .wdata_i (bank_wdata),
        .be_i    (bank_be),
        .rdata_o (bank_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q <= 1'b0;
            rd_err_q <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            rd_vld_q <= acc && !req_we;
            rd_err_q <= acc && !req_we && !in_range;
            wr_err_q <= acc && req_we && !in_range;
        end
    end

    // Out-of-range reads never touched the bank, so their data is forced to zero here.
    assign s1_data = (rd_vld_q && !rd_err_q) ? bank_rdata : '0;

    if (RD_LAT == 2) begin : g_lat2
        logic              vld2_q, err2_q;
        logic [DATA_W-1:0] data2_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                vld2_q  <= 1'b0;
                err2_q  <= 1'b0;
                data2_q <= '0;
            end else begin
                vld2_q  <= rd_vld_q;
                err2_q  <= rd_err_q;
                data2_q <= s1_data;
            end
        end
        assign out_vld  = vld2_q;
        assign out_err  = err2_q;
        assign out_data = data2_q;
    end else begin : g_lat1
        assign out_vld  = rd_vld_q;
        assign out_err  = rd_err_q;
        assign out_data = s1_data;
    end

    // Reset masks the outputs in the same cycle so an in-flight read never surfaces.
    assign req_ready = (state_q == S_IDLE) && !rst;
    assign busy      = rst ? (CLEAR_ON_RESET != 0) : (state_q == S_CLEAR);
    assign rsp_valid = out_vld && !rst;
    assign rsp_err   = out_err && !rst;
    assign rsp_rdata = rst ? '0 : out_data;
    assign wr_err    = wr_err_q && !rst;

endmodule
